// File: rtl/tt_checker_if.sv
// Stimulus/response and result bundle between a truth-table checker and the block driving it.
// No flow control: vld qualifies one vector per cycle, and results are held registers.
interface tt_checker_if;
    logic       start;
    logic       vld;
    logic       a;
    logic       b;
    logic       c;
    logic       f;
    logic       g;
    logic       h;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [3:0] err_cnt;
    logic       fail_seen;
    logic [2:0] first_fail;
    logic [7:0] cov;

    modport master (
        output start, vld, a, b, c, f, g, h,
        input  busy, done, pass, timeout, err_cnt, fail_seen, first_fail, cov
    );

    modport slave (
        input  start, vld, a, b, c, f, g, h,
        output busy, done, pass, timeout, err_cnt, fail_seen, first_fail, cov
    );
endinterface

// File: rtl/tt_checker.sv
// Checks a 3-in/3-out response against expected truth tables; results registered one cycle after the sampled vector.
// No backpressure: every vld cycle in RUN is consumed, and a run ends on full coverage or after TIMEOUT idle cycles.
module tt_checker #(
    parameter logic [7:0] EXP_F   = 8'h00,
    parameter logic [7:0] EXP_G   = 8'h00,
    parameter logic [7:0] EXP_H   = 8'h00,
    parameter logic [7:0] TIMEOUT = 8'd40
) (
    input  logic         clk,
    input  logic         reset,
    tt_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t     state_q,      state_d;
    logic       busy_q,       busy_d;
    logic       done_q,       done_d;
    logic       pass_q,       pass_d;
    logic       timeout_q,    timeout_d;
    logic [3:0] err_cnt_q,    err_cnt_d;
    logic       fail_seen_q,  fail_seen_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic [7:0] cov_q,        cov_d;
    logic [7:0] idle_cnt_q,   idle_cnt_d;

    logic [2:0] idx;
    logic [2:0] exp_fgh;
    logic       mismatch;

    assign idx      = {bus.a, bus.b, bus.c};
    assign exp_fgh  = {EXP_F[idx], EXP_G[idx], EXP_H[idx]};
    assign mismatch = ({bus.f, bus.g, bus.h} != exp_fgh);

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        err_cnt_d    = err_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        cov_d        = cov_q;
        idle_cnt_d   = idle_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_RUN;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    err_cnt_d    = 4'h0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = 3'b000;
                    cov_d        = 8'h00;
                    idle_cnt_d   = 8'h00;
                end
            end
            ST_RUN: begin
                if (bus.vld) begin
                    cov_d      = cov_q | (8'b1 << idx);
                    idle_cnt_d = 8'h00;
                    if (mismatch) begin
                        if (err_cnt_q != 4'hF) begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                        if (!fail_seen_q) begin
                            fail_seen_d  = 1'b1;
                            first_fail_d = idx;
                        end
                    end
                end else if (idle_cnt_q != 8'hFF) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end

                // Coverage is tested first so a covering vector always beats the idle limit.
                if (cov_d == 8'hFF) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 4'h0) && !timeout_d;
                end else if (!bus.vld && (idle_cnt_d >= TIMEOUT)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= 4'h0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 3'b000;
            cov_q        <= 8'h00;
            idle_cnt_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
            cov_q        <= cov_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.timeout    = timeout_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_seen  = fail_seen_q;
    assign bus.first_fail = first_fail_q;
    assign bus.cov        = cov_q;

endmodule

// File: tb/tb_tt_checker.sv
// Bench for tt_checker: directed scenarios plus random traffic, all checked against a behavioural model.
// Expected responses come from parity / majority / AND of {a,b,c}, not from the parameter tables.
module tb_tt_checker;

    localparam int TMO = 5;

    logic clk;
    logic reset;

    tt_checker_if bus ();

    tt_checker #(
        .EXP_F   (8'h96),
        .EXP_G   (8'hE8),
        .EXP_H   (8'h80),
        .TIMEOUT (8'd5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int busy_cnt;

    // Reference model state: 0 idle, 1 running, 2 finished
    int         m_phase;
    int         m_idle;
    logic [7:0] m_cov;
    int         m_err;
    logic       m_fs;
    logic [2:0] m_ff;
    logic       m_pass;
    logic       m_to;
    logic       m_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] golden(input logic [2:0] abc);
        logic a, b, c;
        {a, b, c} = abc;
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c), a & b & c};
    endfunction

    task automatic m_reset();
        m_phase = 0; m_idle = 0; m_cov = 8'h00; m_err = 0;
        m_fs = 1'b0; m_ff = 3'b000; m_pass = 1'b0; m_to = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic v, input logic [2:0] abc, input logic [2:0] fgh);
        m_done = 1'b0;
        if (m_phase != 1) begin
            if (st) begin
                m_phase = 1; m_idle = 0; m_cov = 8'h00; m_err = 0;
                m_fs = 1'b0; m_ff = 3'b000; m_pass = 1'b0; m_to = 1'b0;
            end
        end else begin
            if (v) begin
                m_cov[abc] = 1'b1;
                m_idle = 0;
                if (fgh != golden(abc)) begin
                    m_err = (m_err < 15) ? m_err + 1 : 15;
                    if (!m_fs) begin
                        m_fs = 1'b1;
                        m_ff = abc;
                    end
                end
            end else begin
                m_idle++;
            end
            if ($countones(m_cov) == 8) begin
                m_phase = 2; m_done = 1'b1; m_pass = (m_err == 0);
            end else if (m_idle >= TMO) begin
                m_phase = 2; m_done = 1'b1; m_to = 1'b1; m_pass = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("busy",       bus.busy,       m_phase == 1);
        check_eq("done",       bus.done,       m_done);
        check_eq("pass",       bus.pass,       m_pass);
        check_eq("timeout",    bus.timeout,    m_to);
        check_eq("err_cnt",    bus.err_cnt,    m_err);
        check_eq("fail_seen",  bus.fail_seen,  m_fs);
        check_eq("first_fail", bus.first_fail, m_ff);
        check_eq("cov",        bus.cov,        m_cov);
    endtask

    task automatic step(input logic st, input logic v, input logic [2:0] abc, input logic [2:0] flip);
        logic [2:0] fgh;
        fgh = golden(abc) ^ flip;
        bus.start = st;
        bus.vld   = v;
        {bus.a, bus.b, bus.c} = abc;
        {bus.f, bus.g, bus.h} = fgh;
        model_step(st, v, abc, fgh);
        @(posedge clk);
        #1;
        if (bus.busy) busy_cnt++;
        check_outputs();
        bus.start = 1'b0;
        bus.vld   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom), 3'($urandom));
    endtask

    task automatic wait_done(input int max_cycles);
        int k;
        k = 0;
        while (!bus.done && k < max_cycles) begin
            idle(1);
            k++;
        end
        check_eq("done_wait", bus.done, 1'b1);
    endtask

    // Full clean sweep 000..111; optionally flip g on one vector.
    task automatic sweep(input logic inject, input logic [2:0] bad);
        busy_cnt = 0;
        step(1'b1, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i), (inject && 3'(i) == bad) ? 3'b010 : 3'b000);
        end
        check_eq("done_lat", bus.done, 1'b1);
        check_eq("busy_cycles", busy_cnt, 8);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; busy_cnt = 0;
        bus.start = 1'b0; bus.vld = 1'b0;
        bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0;
        bus.f = 1'b0; bus.g = 1'b0; bus.h = 1'b0;
        reset = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // vld while idle must not touch coverage
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'(i), 3'b000);
        check_eq("idle_cov", bus.cov, 8'h00);

        // Exhaustive clean run
        sweep(1'b0, 3'b000);
        check_eq("x_pass", bus.pass, 1'b1);
        check_eq("x_err", bus.err_cnt, 4'h0);
        check_eq("x_cov", bus.cov, 8'hFF);
        idle(2);
        check_eq("x_hold", bus.pass, 1'b1);

        // Single fault on g at 011
        sweep(1'b1, 3'b011);
        check_eq("sf_err", bus.err_cnt, 4'h1);
        check_eq("sf_ff", bus.first_fail, 3'b011);
        check_eq("sf_pass", bus.pass, 1'b0);

        // Repeats with 3-cycle gaps
        step(1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b1, 3'b000, 3'b000); idle(3);
        step(1'b0, 1'b1, 3'b000, 3'b000); idle(3);
        step(1'b0, 1'b1, 3'b101, 3'b100); idle(3);
        step(1'b0, 1'b1, 3'b101, 3'b100); idle(3);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] rest [6];
            rest = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
            step(1'b0, 1'b1, rest[i], 3'b000);
            if (i < 5) idle(3);
        end
        check_eq("rp_done", bus.done, 1'b1);
        check_eq("rp_err", bus.err_cnt, 4'h2);
        check_eq("rp_ff", bus.first_fail, 3'b101);

        // Timeout after three vectors
        step(1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b1, 3'b001, 3'b000);
        step(1'b0, 1'b1, 3'b100, 3'b000);
        step(1'b0, 1'b1, 3'b111, 3'b000);
        idle(4);
        check_eq("to_early", bus.done, 1'b0);
        idle(1);
        check_eq("to_done", bus.done, 1'b1);
        check_eq("to_flag", bus.timeout, 1'b1);
        check_eq("to_cov", bus.cov, 8'h92);

        // start during a run is ignored
        step(1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b1, 3'b010, 3'b001);
        step(1'b1, 1'b1, 3'b110, 3'b000);
        check_eq("rs_keep", bus.err_cnt, 4'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 3'b000);
        check_eq("rs_err", bus.err_cnt, 4'h1);

        // Saturation then asynchronous reset mid-cycle
        step(1'b1, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'b110, 3'b111);
        check_eq("sat_err", bus.err_cnt, 4'hF);
        #3;
        reset = 1'b1;
        m_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 3'b000);
        check_eq("rst_ign", bus.cov, 8'h00);

        // Restart from a finished run reproduces the clean sweep
        sweep(1'b0, 3'b000);
        sweep(1'b0, 3'b000);
        check_eq("re_pass", bus.pass, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 25) == 0, ($urandom % 3) != 0, 3'($urandom),
                 (($urandom % 10) == 0) ? 3'($urandom) : 3'b000);
        end
        wait_done(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_checker.md
TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 SHALL have parameter EXP_F, default 8'h00, expected f truth table; bit index is {a,b,c}.
REQ-002 SHALL have parameter EXP_G, default 8'h00, expected g truth table, same indexing.
REQ-003 SHALL have parameter EXP_H, default 8'h00, expected h truth table, same indexing.
REQ-004 SHALL have parameter TIMEOUT, default 8'd40: maximum idle cycles between vectors while running.
REQ-005 SHALL have the ports: clk  input  1  clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  starts a check run (single-cycle pulse).
REQ-008 vld  input  1  a/b/c/f/g/h are valid this cycle.
REQ-009 a, b, c  input  1 each  applied stimulus vector.
REQ-010 f, g, h  input  1 each  observed DUT response to a/b/c.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 pass  output  1  held result: all 8 vectors covered, zero errors, no timeout.
REQ-014 timeout  output  1  held: run ended by TIMEOUT.
REQ-015 err_cnt  output  4  mismatching vectors, saturating.
REQ-016 fail_seen  output  1  at least one mismatch this run.
REQ-017 first_fail  output  3  {a,b,c} of first mismatch; valid only when fail_seen=1.
REQ-018 cov  output  8  coverage bitmap; bit {a,b,c} set once that vector is seen.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; encoding is free.
REQ-020 IDLE: start=1 -> RUN next cycle, clearing cov, err_cnt, fail_seen, first_fail, pass, timeout and the idle counter.
REQ-021 RUN: each cycle with vld=1, idx={a,b,c}; mismatch = f!=EXP_F[idx] or g!=EXP_G[idx] or h!=EXP_H[idx].
REQ-022 Mismatch: err_cnt +1, saturating at 4'hF.
REQ-023 First mismatch of a run: fail_seen<=1 and first_fail<=idx; later mismatches do not change first_fail.
REQ-024 Every vld cycle in RUN sets cov[idx]; a repeated vector is rechecked and counted again.
REQ-025 Transition to DONE: the cycle after cov becomes 8'hFF, including the update made by the same vld cycle.
REQ-026 The idle counter: cleared on each vld=1 cycle in RUN; otherwise increments.
REQ-027 Idle counter reaching TIMEOUT: timeout<=1 and RUN->DONE.
REQ-028 If the final covering vld and the timeout occur in the same cycle, coverage wins and timeout stays 0.
REQ-029 done=1 for exactly the single cycle of entry into DONE.
REQ-030 On DONE entry, pass<=(cov==8'hFF && err_cnt==0 && !timeout), evaluated on the post-update values.
REQ-031 busy=1 exactly while in RUN.
REQ-032 vld in IDLE or DONE is ignored.
REQ-033 start in RUN is ignored.
REQ-034 start in DONE restarts exactly as in REQ-020.
REQ-035 DONE holds all result outputs until restart or reset.
REQ-036 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-037 reset=1 SHALL immediately force IDLE with busy=0, done=0, pass=0, timeout=0, err_cnt=0, fail_seen=0, first_fail=0, cov=0 and idle counter=0, regardless of clock.
REQ-038 Reset asserted mid-run SHALL discard the run; after release the block waits for a new start.

Verification
REQ-039 Exhaustive pass: EXP_F=8'h96, EXP_G=8'hE8, EXP_H=8'h80; start, then 8 vld cycles abc=000..111 with matching f/g/h -> busy 8 cycles, done pulse 1 cycle later, pass=1, err_cnt=0, cov=8'hFF.
REQ-040 Single fault: same as REQ-039 with g inverted at abc=011 -> err_cnt=1, fail_seen=1, first_fail=3'b011, pass=0.
REQ-041 Repeats with gaps: vectors 000,000,101 (wrong f),101 (wrong f), then the remaining six correct, with 3-cycle gaps -> err_cnt=2, first_fail=3'b101, done after cov=8'hFF.
REQ-042 Timeout: TIMEOUT=8'd5, start, 3 vectors, then idle -> done 5 idle cycles after the last vld, timeout=1, pass=0, cov holds 3 bits.
REQ-043 Saturation and reset: 20 mismatching vld cycles on a single vector -> err_cnt=4'hF; assert reset between clock edges -> all outputs 0 immediately, state IDLE, vld ignored until start.
REQ-044 Control edge cases: vld in IDLE -> cov stays 0; start during RUN -> no clearing; start in DONE -> clean restart reproducing REQ-039.
